// File: rtl/toggle_hs_rx.sv
// Receiving end of a two-phase (toggle) req/ack handshake. It presents each new
// word on a valid/ready port and answers by inverting ack_tog once the word is consumed.
module toggle_hs_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tog,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_tog,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  evt_count,
  output logic              proto_err
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                   state_reg, state_next;
  logic [SYNC_STAGES-1:0]   sync_reg;
  logic [SYNC_STAGES-1:0]   sync_d;
  logic                     prev_reg, prev_next;
  logic                     ack_reg, ack_next;
  logic [DATA_W-1:0]        data_reg, data_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic                     err_reg, err_next;
  logic                     sync_s;
  logic                     req_edge;

  // Stage 0 samples the asynchronous toggle; each later stage follows its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = req_tog;
      end else begin : g_rest
        assign sync_d[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign sync_s   = sync_reg[SYNC_STAGES-1];
  assign req_edge = sync_s ^ prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg  <= '0;
      state_reg <= IDLE;
      prev_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      sync_reg  <= sync_d;
      state_reg <= state_next;
      prev_reg  <= prev_next;
      ack_reg   <= ack_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    ack_next   = ack_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_edge) begin
          data_next  = data_in;
          prev_next  = sync_s;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ack_next   = ~ack_reg;
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = IDLE;
        end
        // A toggle while a word is still held is flagged and dropped; the held word stays.
        if (req_edge) begin
          err_next  = 1'b1;
          prev_next = sync_s;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state_reg == HOLD);
  assign out_data  = data_reg;
  assign ack_tog   = ack_reg;
  assign evt_count = cnt_reg;
  assign proto_err = err_reg;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Bench for toggle_hs_rx: directed scenarios plus random traffic, all checked
// against an edge-by-edge behavioural model kept in this file.
module tb_toggle_hs_rx;

  localparam int DW = 8;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_tog = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          out_ready = 1'b0;

  logic          ack_tog, out_valid, proto_err;
  logic [DW-1:0] out_data;
  logic [15:0]   evt_count;
  logic          ack_w, valid_w, err_w;
  logic [DW-1:0] data_w;
  logic [1:0]    cnt_w;

  int n_vec = 0;
  int n_err = 0;

  toggle_hs_rx #(.DATA_W(DW), .SYNC_STAGES(S), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_tog(req_tog), .data_in(data_in),
    .ack_tog(ack_tog), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .evt_count(evt_count), .proto_err(proto_err)
  );

  // Narrow-counter copy on the same stimulus, for the wrap-around behaviour.
  toggle_hs_rx #(.DATA_W(DW), .SYNC_STAGES(S), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .req_tog(req_tog), .data_in(data_in),
    .ack_tog(ack_w), .out_data(data_w), .out_valid(valid_w),
    .out_ready(out_ready), .evt_count(cnt_w), .proto_err(err_w)
  );

  always #5 clk = ~clk;

  // Reference model: the receiver sees the sender's level S edges late; any
  // difference from the last level it took note of is a new event.
  int          n_edge = 0;
  int          rst_edge = 0;
  logic        hist [8];
  logic        m_seen = 1'b0, m_valid = 1'b0, m_ack = 1'b0, m_err = 1'b0;
  logic [DW-1:0] m_data = '0;
  int unsigned m_cnt = 0;

  task automatic model_step();
    logic seen_lvl;
    n_edge++;
    if (reset) begin
      rst_edge = n_edge;
      m_valid = 1'b0; m_data = '0; m_ack = 1'b0; m_err = 1'b0; m_cnt = 0; m_seen = 1'b0;
    end else begin
      seen_lvl = (n_edge - S > rst_edge) ? hist[(n_edge - S) % 8] : 1'b0;
      if (!m_valid) begin
        if (seen_lvl != m_seen) begin
          m_valid = 1'b1; m_data = data_in; m_seen = seen_lvl;
        end
      end else begin
        if (out_ready) begin
          m_valid = 1'b0; m_ack = ~m_ack; m_cnt++;
        end
        if (seen_lvl != m_seen) begin
          m_err = 1'b1; m_seen = seen_lvl;
        end
      end
    end
    hist[n_edge % 8] = req_tog;
  endtask

  function automatic logic [39:0] pack_dut();
    return {out_valid, out_data, ack_tog, proto_err, evt_count,
            valid_w, data_w, ack_w, err_w, cnt_w};
  endfunction

  function automatic logic [39:0] pack_model();
    logic [15:0] c16;
    logic [1:0]  c2;
    c16 = m_cnt[15:0];
    c2  = m_cnt[1:0];
    return {m_valid, m_data, m_ack, m_err, c16, m_valid, m_data, m_ack, m_err, c2};
  endfunction

  // Every wait goes through here so the model sees every clock edge.
  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic do_reset();
    reset = 1'b1; req_tog = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_tog = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_vec++;
    if (pack_dut() !== 40'd0) begin
      n_err++; $display("FAIL reset_state: got %h want %h", pack_dut(), 40'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || pack_dut() !== pack_model()) begin
        n_err++; $display("FAIL reset_idle: got %h want %h", pack_dut(), pack_model());
      end
    end
  endtask

  task automatic test_single();
    logic exp_v;
    do_reset();
    out_ready = 1'b1; data_in = 8'hA5; req_tog = 1'b1;
    for (int i = 1; i <= S + 2; i++) begin
      tick();
      exp_v = (i == S + 1);
      n_vec++;
      if (out_valid !== exp_v || pack_dut() !== pack_model()) begin
        n_err++; $display("FAIL single_c%0d: got v=%b %h want v=%b %h", i, out_valid, pack_dut(), exp_v, pack_model());
      end
      if (i == S + 1) begin
        n_vec++;
        if (out_data !== 8'hA5) begin
          n_err++; $display("FAIL single_data: got %h want a5", out_data);
        end
      end
      if (i == S + 2) begin
        n_vec++;
        if ({ack_tog, evt_count, proto_err} !== {1'b1, 16'd1, 1'b0}) begin
          n_err++; $display("FAIL single_ack: got ack=%b cnt=%0d err=%b want ack=1 cnt=1 err=0", ack_tog, evt_count, proto_err);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int vc = 0;
    bit done = 1'b0;
    out_ready = 1'b0; data_in = 8'hA5; req_tog = ~req_tog;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      n_vec++;
      if (pack_dut() !== pack_model()) begin
        n_err++; $display("FAIL bp_model: got %h want %h", pack_dut(), pack_model());
      end
      if (out_valid) begin
        vc++;
        n_vec++;
        if (out_data !== 8'hA5 || ack_tog !== 1'b1) begin
          n_err++; $display("FAIL bp_hold: got data=%h ack=%b want data=a5 ack=1", out_data, ack_tog);
        end
        if (vc == 6) out_ready = 1'b1;
      end else if (vc > 0) begin
        done = 1'b1;
      end
    end
    n_vec++;
    if (!done || vc != 6 || ack_tog !== 1'b0) begin
      n_err++; $display("FAIL bp_len: got cycles=%0d ack=%b want cycles=6 ack=0", vc, ack_tog);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    out_ready = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      data_in = DW'(w); req_tog = ~req_tog;
      wait_valid(ok);
      n_vec++;
      if (!ok || out_data !== DW'(w)) begin
        n_err++; $display("FAIL b2b_word%0d: got valid=%b data=%h want valid=1 data=%h", w, ok, out_data, DW'(w));
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || pack_dut() !== pack_model()) begin
        n_err++; $display("FAIL b2b_pulse%0d: got %h want %h", w, pack_dut(), pack_model());
      end
    end
    tick(); tick(); tick();
    n_vec++;
    if (ack_tog !== 1'b0 || evt_count !== 16'd4 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: got ack=%b cnt=%0d v=%b want ack=0 cnt=4 v=0", ack_tog, evt_count, out_valid);
    end
  endtask

  task automatic test_violation();
    int deliveries = 0;
    do_reset();
    out_ready = 1'b0; data_in = 8'h3C; req_tog = 1'b1;
    tick(); tick(); tick();
    req_tog = 1'b0; data_in = 8'hC3;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (pack_dut() !== pack_model()) begin
        n_err++; $display("FAIL viol_model: got %h want %h", pack_dut(), pack_model());
      end
    end
    n_vec++;
    if ({out_valid, out_data, proto_err} !== {1'b1, 8'h3C, 1'b1}) begin
      n_err++; $display("FAIL viol_hold: got v=%b data=%h err=%b want v=1 data=3c err=1", out_valid, out_data, proto_err);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) deliveries++;
      tick();
    end
    n_vec++;
    if (deliveries != 1 || evt_count !== 16'd1 || proto_err !== 1'b1) begin
      n_err++; $display("FAIL viol_deliver: got words=%0d cnt=%0d err=%b want words=1 cnt=1 err=1", deliveries, evt_count, proto_err);
    end
  endtask

  task automatic test_wrap_reset();
    bit ok;
    do_reset();
    out_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      data_in = DW'($urandom); req_tog = ~req_tog;
      wait_valid(ok);
      n_vec++;
      if (!ok || out_data !== data_in) begin
        n_err++; $display("FAIL wrap_xfer%0d: got valid=%b data=%h want valid=1 data=%h", w, ok, out_data, data_in);
      end
      tick();
    end
    n_vec++;
    if (cnt_w !== 2'd1 || evt_count !== 16'd5) begin
      n_err++; $display("FAIL wrap_count: got narrow=%0d wide=%0d want narrow=1 wide=5", cnt_w, evt_count);
    end
    out_ready = 1'b0; req_tog = ~req_tog;
    wait_valid(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL wrap_hold: got valid=0 want valid=1");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; req_tog = 1'b0;
    n_vec++;
    if ({out_valid, ack_tog, evt_count, cnt_w, valid_w} !== 20'd0) begin
      n_err++; $display("FAIL mid_reset: got v=%b ack=%b cnt=%0d narrow=%0d want all 0", out_valid, ack_tog, evt_count, cnt_w);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom % 2);
      if ($urandom % 6 == 0) begin
        req_tog = ~req_tog; data_in = DW'($urandom);
      end
      tick();
      n_vec++;
      if (pack_dut() !== pack_model()) begin
        n_err++; $display("FAIL random_c%0d: got %h want %h", i, pack_dut(), pack_model());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_violation();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
